// File: rtl/odd_parity_gen.sv
// Registered parity generator for a DATA_W-bit word with a matching frame checker.
// Generator and checker share nothing but the clock and reset, so TX and RX can run together.
module odd_parity_gen #(
  parameter int DATA_W = 8,
  parameter bit ODD    = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             data_in,
  output logic                          out_valid,
  output logic                          parity_out,
  output logic [DATA_W-1:0]             data_out,
  output logic [DATA_W:0]               frame_out,
  output logic [$clog2(DATA_W+1)-1:0]   ones_count,
  input  logic                          chk_valid,
  input  logic [DATA_W:0]               chk_frame,
  output logic                          chk_done,
  output logic                          chk_err
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic              w_parity;
  logic [CNT_W-1:0]  w_ones;
  logic              w_chk_err;

  logic              r_out_valid;
  logic              r_parity;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_ones;
  logic              r_chk_done;
  logic              r_chk_err;

  // Odd parity sets the bit when the word already holds an even number of ones.
  assign w_parity  = ODD ? ~^data_in : ^data_in;
  assign w_chk_err = ODD ? ~^chk_frame : ^chk_frame;

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_ones = '0;
    for (int i = 0; i < DATA_W; i++) begin
      w_ones = w_ones + CNT_W'(data_in[i]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_parity    <= 1'b0;
      r_data      <= '0;
      r_ones      <= '0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_parity <= w_parity;
        r_data   <= data_in;
        r_ones   <= w_ones;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chk_done <= 1'b0;
      r_chk_err  <= 1'b0;
    end else begin
      r_chk_done <= chk_valid;
      if (chk_valid) begin
        r_chk_err <= w_chk_err;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign parity_out = r_parity;
  assign data_out   = r_data;
  assign frame_out  = {r_parity, r_data};
  assign ones_count = r_ones;
  assign chk_done   = r_chk_done;
  assign chk_err    = r_chk_err;

endmodule

// File: tb/tb_odd_parity_gen.sv
// Directed self-checking bench for odd_parity_gen (DATA_W=8, ODD=1).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_odd_parity_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] data_in;
  logic       out_valid;
  logic       parity_out;
  logic [7:0] data_out;
  logic [8:0] frame_out;
  logic [3:0] ones_count;
  logic       chk_valid;
  logic [8:0] chk_frame;
  logic       chk_done;
  logic       chk_err;

  int n_pass  = 0;
  int n_total = 0;

  odd_parity_gen #(.DATA_W(8), .ODD(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .data_in    (data_in),
    .out_valid  (out_valid),
    .parity_out (parity_out),
    .data_out   (data_out),
    .frame_out  (frame_out),
    .ones_count (ones_count),
    .chk_valid  (chk_valid),
    .chk_frame  (chk_frame),
    .chk_done   (chk_done),
    .chk_err    (chk_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] sweep_data [10] = '{8'b11101010, 8'b10111010, 8'b10101110, 8'b10101011,
                                  8'b10101010, 8'b10101000, 8'b10100010, 8'b11111110,
                                  8'b00101010, 8'b10001010};
  logic       sweep_par  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  int         sweep_ones [10] = '{5, 5, 5, 5, 4, 3, 3, 7, 3, 3};

  initial begin
    // Reset held while valid inputs are presented.
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    data_in   = 8'hFF;
    chk_valid = 1'b1;
    chk_frame = 9'h000;
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_parity", 32'(parity_out), 32'd0);
    check("rst_ones", 32'(ones_count), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_chk_done", 32'(chk_done), 32'd0);
    check("rst_chk_err", 32'(chk_err), 32'd0);

    // First capture after release.
    rst_n     = 1'b1;
    chk_valid = 1'b0;
    tick();
    check("first_parity", 32'(parity_out), 32'd1);
    check("first_ones", 32'(ones_count), 32'd8);
    check("first_valid", 32'(out_valid), 32'd1);

    // Sweep, one word per cycle, feeding the previous frame back to the checker.
    for (int i = 0; i < 10; i++) begin
      data_in   = sweep_data[i];
      in_valid  = 1'b1;
      chk_valid = (i > 0);
      chk_frame = frame_out;
      tick();
      check($sformatf("sweep_parity[%0d]", i), 32'(parity_out), 32'(sweep_par[i]));
      check($sformatf("sweep_ones[%0d]", i), 32'(ones_count), 32'(sweep_ones[i]));
      check($sformatf("sweep_valid[%0d]", i), 32'(out_valid), 32'd1);
      check($sformatf("sweep_frame[%0d]", i), 32'(frame_out), 32'({sweep_par[i], sweep_data[i]}));
      if (i > 0) begin
        check($sformatf("loop_done[%0d]", i), 32'(chk_done), 32'd1);
        check($sformatf("loop_err[%0d]", i), 32'(chk_err), 32'd0);
      end
    end
    in_valid  = 1'b0;
    chk_valid = 1'b1;
    chk_frame = frame_out;
    tick();
    check("loop_done_last", 32'(chk_done), 32'd1);
    check("loop_err_last", 32'(chk_err), 32'd0);
    chk_valid = 1'b0;

    // Extremes.
    in_valid = 1'b1;
    data_in  = 8'h00;
    tick();
    check("zero_parity", 32'(parity_out), 32'd1);
    check("zero_ones", 32'(ones_count), 32'd0);
    check("zero_frame", 32'(frame_out), 32'h100);
    data_in = 8'hFF;
    tick();
    check("ff_parity", 32'(parity_out), 32'd1);
    check("ff_ones", 32'(ones_count), 32'd8);

    // Single-cycle pulse, then idle with garbage on data_in.
    data_in = 8'hAA;
    tick();
    check("pulse_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    data_in  = 8'h01;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("idle_valid[%0d]", i), 32'(out_valid), 32'd0);
      check($sformatf("idle_parity[%0d]", i), 32'(parity_out), 32'd1);
      check($sformatf("idle_data[%0d]", i), 32'(data_out), 32'hAA);
    end

    // Checker with hand-built frames.
    chk_valid = 1'b1;
    chk_frame = 9'h1AA;
    tick();
    check("chk_good_done", 32'(chk_done), 32'd1);
    check("chk_good_err", 32'(chk_err), 32'd0);
    chk_frame = 9'h0AA;
    tick();
    check("chk_bad_err", 32'(chk_err), 32'd1);
    chk_valid = 1'b0;
    chk_frame = 9'h1AA;
    tick();
    check("chk_idle_done", 32'(chk_done), 32'd0);
    check("chk_idle_err_hold", 32'(chk_err), 32'd1);

    // Async reset dropped between edges during a burst on both sides.
    in_valid  = 1'b1;
    data_in   = 8'h0F;
    chk_valid = 1'b1;
    chk_frame = 9'h0AA;
    tick();
    check("burst_parity", 32'(parity_out), 32'd1);
    check("burst_ones", 32'(ones_count), 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_parity", 32'(parity_out), 32'd0);
    check("async_data", 32'(data_out), 32'd0);
    check("async_ones", 32'(ones_count), 32'd0);
    check("async_frame", 32'(frame_out), 32'd0);
    check("async_chk_done", 32'(chk_done), 32'd0);
    check("async_chk_err", 32'(chk_err), 32'd0);
    tick();
    rst_n     = 1'b1;
    chk_valid = 1'b0;
    data_in   = 8'h01;
    tick();
    check("cold_parity", 32'(parity_out), 32'd0);
    check("cold_ones", 32'(ones_count), 32'd1);
    check("cold_valid", 32'(out_valid), 32'd1);
    check("cold_chk_done", 32'(chk_done), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
